pipelined_shifter: RTL
======================

Name: pipelined_shifter

Overview:
- Parametrised, pipelined barrel shifter. It is the successor to the single-stage 4-bit shift block.
- It supports any power-of-two WIDTH and full shift amounts 0..WIDTH-1, using one log2 stage per shift-amount bit.
- A register sits after every stage, and valid/ready handshakes run at both ends.
- It sits in the execute unit beside the ALU. It serves the SLLI/SRLI/ROLI/RORI/SRAI-class instructions when the pipelined datapath is enabled.

Parameters:
- WIDTH, 16, data width in bits; power of two, minimum 4.
- TAG_W, 4, width of the sideband tag carried alongside each beat (e.g. destination register id).
- STAGES, $clog2(WIDTH), number of shift stages and pipeline latency in cycles; derived, not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; kills all in-flight beats.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_op  in  3  0 ROL, 1 SLL, 2 SRA, 3 SRL, 4 ROR; 5-7 reserved.
- in_data  in  WIDTH  operand.
- in_amt  in  STAGES  shift amount.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the beat.
- out_err  out  1  beat carried a reserved op; out_data equals the input data unshifted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits clear to 0, so out_valid=0;
  - out_data, out_tag and out_err clear to 0;
  - in_ready=1 once reset is released.
- Stage k (k=0..STAGES-1) shifts by 2^k when amt bit k is set, otherwise passes data through.
  - Op, remaining amount and tag travel with the data.
  - Each stage output is registered. Latency is STAGES cycles from acceptance to out_valid (4 at WIDTH=16).
- Op semantics:
  - ROL/ROR: bits wrap around.
  - SLL: zero-fill at the LSBs.
  - SRL: zero-fill at the MSBs.
  - SRA: fill with the original in_data MSB; the sign is captured at acceptance and carried down the pipe.
  - Amount 0 returns in_data unchanged for every op.
- Reserved op: the data passes through unshifted and out_err=1 on that beat. It is not dropped.
- Stall and throughput:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall; the signal is combinational and has no dependence on in_valid.
  - A beat is accepted when in_valid & in_ready.
  - On stall, every stage holds, including bubbles. No beat is lost or duplicated.
  - Throughput is 1 beat/cycle with no stall. Order is strictly preserved.
- Bubbles: an empty stage register never asserts valid downstream. Output fields are don't-care-but-stable when out_valid=0; the implementation holds the last value.
- Flush:
  - On the clock edge with flush=1, all valid bits clear. out_valid=0 on the next cycle.
  - A beat presented with in_valid & in_ready in the flush cycle is discarded. The producer sees it as accepted.
  - Flush takes priority over stall.
- Reset mid-operation: all in-flight beats are dropped immediately, and out_valid falls asynchronously.
- Width rules:
  - in_amt is exactly STAGES bits, so an amount ≥ WIDTH is not representable.
  - Intermediate values are WIDTH bits, and no carries are produced.

Decomposition:
- Shared package shift_pkg holds:
  - the op enum (SH_ROL, SH_SLL, SH_SRA, SH_SRL, SH_ROR);
  - the SH_OP_W=3 constant;
  - a function is_reserved_op().
- One sub-module, shift_stage, is parametrised by WIDTH and DIST (=2^k). It is purely combinational: a single-distance conditional shift with fill select.
- The top level generates STAGES instances of shift_stage plus their pipeline registers, valid bits and stall logic.

Test Plan (WIDTH=16, latency 4):
- ROL 0x1234 amt 4, tag 3 -> after 4 cycles out_data 0x2341, out_tag 3, out_err 0. ROR 0x1234 amt 4 -> 0x4123.
- SRA 0x8000 amt 15 -> 0xFFFF. SRL 0x8000 amt 15 -> 0x0001. SLL 0x00FF amt 0 -> 0x00FF.
- 8 back-to-back beats (SLL 0x0001 amt 0..7):
  - with out_ready=1: results 0x0001..0x0080 on consecutive cycles, in order.
  - with out_ready low for 3 cycles mid-stream: in_ready low during the stall, output held stable, no loss or duplication.
- Reserved op 6 on 0xBEEF amt 5 -> out_data 0xBEEF, out_err 1. The following valid beat has out_err 0.
- Flush with 3 beats in flight plus 1 presented the same cycle -> out_valid stays 0 for the next 5 cycles. A subsequent beat emerges with correct latency.
- rst_n pulsed low mid-stream (asynchronously, between edges) -> out_valid 0 immediately. After release, in_ready=1 and a new ROL 0x0F00 amt 8 -> 0x000F.

Source files
------------

// File: rtl/pipelined_shifter_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the pipelined barrel shifter:
//   - sh_op_e        : operation encoding carried with every beat
//   - SH_OP_W        : width of the operation field
//   - is_reserved_op : flags encodings 5..7, which pass data through unshifted
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int SH_OP_W = 3;

    typedef enum logic [SH_OP_W-1:0] {
        SH_ROL = 3'd0,
        SH_SLL = 3'd1,
        SH_SRA = 3'd2,
        SH_SRL = 3'd3,
        SH_ROR = 3'd4
    } sh_op_e;

    // Any encoding above SH_ROR has no defined shift and is reported as an error.
    function automatic logic is_reserved_op(input logic [SH_OP_W-1:0] op);
        return (op > 3'd4);
    endfunction

endpackage : shift_pkg

// File: rtl/pipelined_shifter_if.sv
// -----------------------------------------------------------------------------
// pipelined_shifter_if
// Groups both valid/ready handshakes of the pipelined shifter.
//   Producer side : in_valid, in_ready, in_op, in_data, in_amt, in_tag
//   Consumer side : out_valid, out_ready, out_data, out_tag, out_err
// Modports:
//   master : the environment (drives operands, consumes results)
//   slave  : the shifter itself
// -----------------------------------------------------------------------------
interface pipelined_shifter_if
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    localparam int STAGES = $clog2(WIDTH);

    logic                in_valid;
    logic                in_ready;
    logic [SH_OP_W-1:0]  in_op;
    logic [WIDTH-1:0]    in_data;
    logic [STAGES-1:0]   in_amt;
    logic [TAG_W-1:0]    in_tag;

    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [TAG_W-1:0]    out_tag;
    logic                out_err;

    modport master (
        output in_valid, in_op, in_data, in_amt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_op, in_data, in_amt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );

endinterface : pipelined_shifter_if

// File: rtl/pipelined_shifter_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// Purely combinational single-distance shifter: when i_en is set the data is
// moved by DIST positions in the direction implied by i_op, otherwise it
// passes through untouched.
// Ports:
//   i_en   : apply the shift at this stage (amount bit set, op not reserved)
//   i_op   : operation (shift_pkg::sh_op_e encoding)
//   i_sign : sign bit captured at acceptance, used as SRA fill
//   i_data : stage input data
//   o_data : stage output data
// -----------------------------------------------------------------------------
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
)
(
    input  logic                i_en,
    input  logic [SH_OP_W-1:0]  i_op,
    input  logic                i_sign,
    input  logic [WIDTH-1:0]    i_data,
    output logic [WIDTH-1:0]    o_data
);

    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_srl;
    logic [WIDTH-1:0] w_sra;

    // Left moves differ only in what fills the vacated LSBs.
    assign w_rol = {i_data[WIDTH-DIST-1:0], i_data[WIDTH-1:WIDTH-DIST]};
    assign w_sll = {i_data[WIDTH-DIST-1:0], {DIST{1'b0}}};

    // Right moves differ only in what fills the vacated MSBs. SRA uses the
    // sign captured at acceptance, not the current MSB, because earlier
    // stages may already have replaced it.
    assign w_ror = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
    assign w_srl = {{DIST{1'b0}}, i_data[WIDTH-1:DIST]};
    assign w_sra = {{DIST{i_sign}}, i_data[WIDTH-1:DIST]};

    // Select the shifted variant for this op, or pass through when disabled.
    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                SH_ROL:  o_data = w_rol;
                SH_SLL:  o_data = w_sll;
                SH_SRA:  o_data = w_sra;
                SH_SRL:  o_data = w_srl;
                SH_ROR:  o_data = w_ror;
                default: o_data = i_data;
            endcase
        end else begin
            o_data = i_data;
        end
    end

endmodule : shift_stage

// File: rtl/pipelined_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_shifter
// Pipelined barrel shifter with log2(WIDTH) registered stages. Stage k moves
// the data by 2^k when amount bit k is set. Op, amount, tag, sign and the
// reserved-op flag travel down the pipe alongside the data.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears every stage
//   flush : synchronous flush, kills all in-flight beats (wins over stall)
//   bus   : pipelined_shifter_if.slave, producer and consumer handshakes
// Latency is STAGES cycles from acceptance to out_valid; one beat per cycle
// when the consumer is ready. When the output is stalled the whole pipe,
// bubbles included, holds.
// -----------------------------------------------------------------------------
module pipelined_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    pipelined_shifter_if.slave   bus
);

    localparam int STAGES = $clog2(WIDTH);

    // Pipeline registers behind every stage. Op, amount and sign are only
    // needed by a later stage, so the last stage does not keep them.
    logic [STAGES-1:0]   r_valid;
    logic [STAGES-1:0]   r_err;
    logic [WIDTH-1:0]    r_data [STAGES];
    logic [TAG_W-1:0]    r_tag  [STAGES];
    logic [SH_OP_W-1:0]  r_op   [STAGES-1];
    logic [STAGES-1:0]   r_amt  [STAGES-1];
    logic [STAGES-2:0]   r_sign;

    // Combinational view of what each stage sees and produces.
    logic [STAGES-1:0]   w_st_valid;
    logic [STAGES-1:0]   w_st_err;
    logic [STAGES-1:0]   w_st_sign;
    logic [STAGES-1:0]   w_st_en;
    logic [WIDTH-1:0]    w_st_din  [STAGES];
    logic [WIDTH-1:0]    w_st_dout [STAGES];
    logic [TAG_W-1:0]    w_st_tag  [STAGES];
    logic [SH_OP_W-1:0]  w_st_op   [STAGES];
    logic [STAGES-1:0]   w_st_amt  [STAGES];

    logic                w_stall;

    // A full output that the consumer refuses freezes the entire pipe.
    assign w_stall      = r_valid[STAGES-1] & ~bus.out_ready;
    assign bus.in_ready = ~w_stall;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                // The head stage is fed straight from the producer. The sign
                // is captured here so SRA fills correctly at every distance.
                assign w_st_valid[0] = bus.in_valid;
                assign w_st_din[0]   = bus.in_data;
                assign w_st_tag[0]   = bus.in_tag;
                assign w_st_op[0]    = bus.in_op;
                assign w_st_amt[0]   = bus.in_amt;
                assign w_st_sign[0]  = bus.in_data[WIDTH-1];
                assign w_st_err[0]   = is_reserved_op(bus.in_op);
            end else begin : g_body
                assign w_st_valid[k] = r_valid[k-1];
                assign w_st_din[k]   = r_data[k-1];
                assign w_st_tag[k]   = r_tag[k-1];
                assign w_st_op[k]    = r_op[k-1];
                assign w_st_amt[k]   = r_amt[k-1];
                assign w_st_sign[k]  = r_sign[k-1];
                assign w_st_err[k]   = r_err[k-1];
            end

            // Reserved ops never shift, whatever the amount says.
            assign w_st_en[k] = w_st_amt[k][k] & ~w_st_err[k];

            shift_stage #(
                .WIDTH (WIDTH),
                .DIST  (1 << k)
            ) u_shift_stage (
                .i_en   (w_st_en[k]),
                .i_op   (w_st_op[k]),
                .i_sign (w_st_sign[k]),
                .i_data (w_st_din[k]),
                .o_data (w_st_dout[k])
            );
        end
    endgenerate

    // Pipeline advance: reset clears everything, flush kills valids, stall
    // holds. Payload only loads behind a real beat so that a bubble never
    // disturbs the last value seen on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_err   <= '0;
            r_sign  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
            for (int i = 0; i < STAGES - 1; i++) begin
                r_op[i]  <= '0;
                r_amt[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else if (!w_stall) begin
            for (int i = 0; i < STAGES; i++) begin
                r_valid[i] <= w_st_valid[i];
                if (w_st_valid[i]) begin
                    r_data[i] <= w_st_dout[i];
                    r_tag[i]  <= w_st_tag[i];
                    r_err[i]  <= w_st_err[i];
                end
            end
            for (int i = 0; i < STAGES - 1; i++) begin
                if (w_st_valid[i]) begin
                    r_op[i]   <= w_st_op[i];
                    r_amt[i]  <= w_st_amt[i];
                    r_sign[i] <= w_st_sign[i];
                end
            end
        end
    end

    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.out_data  = r_data[STAGES-1];
    assign bus.out_tag   = r_tag[STAGES-1];
    assign bus.out_err   = r_err[STAGES-1];

endmodule : pipelined_shifter
